sd_data_fifo: RTL and testbench

Single-clock 32-bit word FIFO between the data path state machine (`sd_dpsm`) and the host/DMA side of the SDIO controller. It buffers received card data until the host drains it, and holds host-written data until the DPSM serialises it to the card. `en_rx`/`en_tx` from the DPSM select the transfer direction. The block drives `fifo_full`/`fifo_empty` back to the DPSM and a word count for the `sd_fifocnt` status register.

---
 rtl/sd_pkg.sv | 16 +
 rtl/sd_fifo_ram.sv | 45 ++++
 rtl/sd_data_fifo.sv | 140 ++++++++++++++
 tb/tb_sd_data_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared SDIO controller definitions: data word width and sd_status bit positions.
package sd_pkg;

    localparam int unsigned SD_WORD_W = 32;

    // FIFO-related bit positions within the sd_status register
    localparam int unsigned TXFIFOHE = 14;
    localparam int unsigned RXFIFOHF = 15;
    localparam int unsigned TXFIFOF  = 16;
    localparam int unsigned RXFIFOF  = 17;
    localparam int unsigned TXFIFOE  = 18;
    localparam int unsigned RXFIFOE  = 19;
    localparam int unsigned TXDAVL   = 20;
    localparam int unsigned RXDAVL   = 21;

endpackage

// File: rtl/sd_fifo_ram.sv
// DEPTH x 32 simple dual-port RAM; registered read port that holds when not enabled.
module sd_fifo_ram
    import sd_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [SD_WORD_W-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [SD_WORD_W-1:0] rdata_o
);

    logic [SD_WORD_W-1:0] mem_q [DEPTH];
    logic [SD_WORD_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write: a same-address read returns the old word (needed at full)
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_data_fifo.sv
// SDIO data FIFO between DPSM and host/DMA: direction muxing, pointers, count and sticky errors.
module sd_data_fifo
    import sd_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 sd_clk,
    input  logic                 rst,
    input  logic                 en_rx,
    input  logic                 en_tx,
    input  logic                 flush,
    input  logic                 clr_err,
    input  logic                 dpsm_wr,
    input  logic [SD_WORD_W-1:0] dpsm_dat_i,
    input  logic                 dpsm_rd,
    output logic [SD_WORD_W-1:0] dpsm_dat_o,
    input  logic                 host_wr,
    input  logic [SD_WORD_W-1:0] host_dat_i,
    input  logic                 host_rd,
    output logic [SD_WORD_W-1:0] host_dat_o,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 fifo_half,
    output logic [31:0]          fifocnt,
    output logic                 overrun,
    output logic                 underrun
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_HALF = (AW+1)'(DEPTH / 2);

    logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 full_q, full_d, empty_q, empty_d, half_q, half_d;
    logic                 overrun_q, overrun_d, underrun_q, underrun_d;
    logic                 owner_q, owner_d;  // 1: RAM output register belongs to the DPSM port
    logic [SD_WORD_W-1:0] host_hold_q, host_hold_d, dpsm_hold_q, dpsm_hold_d;
    logic [SD_WORD_W-1:0] wr_data, ram_rdata;
    logic                 wr_sel, rd_sel, rd_tx, is_full, is_empty;
    logic                 wr_ok, rd_ok, ovr_set, und_set;

    always_comb begin
        wr_sel   = en_rx ? dpsm_wr : host_wr;
        wr_data  = en_rx ? dpsm_dat_i : host_dat_i;
        rd_tx    = en_tx & ~en_rx;
        rd_sel   = rd_tx ? dpsm_rd : host_rd;
        is_full  = (count_q == CNT_FULL);
        is_empty = (count_q == '0);
        wr_ok    = ~flush & wr_sel & (~is_full | rd_sel);
        rd_ok    = ~flush & rd_sel & ~is_empty;
        ovr_set  = ~flush & wr_sel & is_full & ~rd_sel;
        und_set  = ~flush & rd_sel & is_empty;
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        owner_d     = owner_q;
        host_hold_d = host_hold_q;
        dpsm_hold_d = dpsm_hold_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) wptr_d = wptr_q + AW'(1);
            if (rd_ok) rptr_d = rptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
        // On a port switch, the port losing the RAM register keeps its last word
        if (rd_ok) begin
            owner_d = rd_tx;
            if (rd_tx && !owner_q) host_hold_d = ram_rdata;
            if (!rd_tx && owner_q) dpsm_hold_d = ram_rdata;
        end
        full_d     = (count_d == CNT_FULL);
        empty_d    = (count_d == '0);
        half_d     = (count_d >= CNT_HALF);
        overrun_d  = flush ? 1'b0 : (ovr_set | (overrun_q & ~clr_err));
        underrun_d = flush ? 1'b0 : (und_set | (underrun_q & ~clr_err));
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            half_q      <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            owner_q     <= 1'b0;
            host_hold_q <= '0;
            dpsm_hold_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            half_q      <= half_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            owner_q     <= owner_d;
            host_hold_q <= host_hold_d;
            dpsm_hold_q <= dpsm_hold_d;
        end
    end

    sd_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (sd_clk),
        .rst_i   (rst),
        .we_i    (wr_ok),
        .waddr_i (wptr_q),
        .wdata_i (wr_data),
        .re_i    (rd_ok),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    assign host_dat_o = owner_q ? host_hold_q : ram_rdata;
    assign dpsm_dat_o = owner_q ? ram_rdata : dpsm_hold_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign fifo_half  = half_q;
    assign fifocnt    = {{(31 - AW){1'b0}}, count_q};
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_sd_data_fifo.sv
// Directed and randomized checks of sd_data_fifo against a queue-based reference model.
module tb_sd_data_fifo;

    localparam int DEPTH = 32;

    logic        sd_clk = 1'b0;
    logic        rst, en_rx, en_tx, flush, clr_err;
    logic        dpsm_wr, dpsm_rd, host_wr, host_rd;
    logic [31:0] dpsm_dat_i, host_dat_i, dpsm_dat_o, host_dat_o, fifocnt;
    logic        fifo_full, fifo_empty, fifo_half, overrun, underrun;

    sd_data_fifo #(.DEPTH(DEPTH)) dut (
        .sd_clk     (sd_clk),
        .rst        (rst),
        .en_rx      (en_rx),
        .en_tx      (en_tx),
        .flush      (flush),
        .clr_err    (clr_err),
        .dpsm_wr    (dpsm_wr),
        .dpsm_dat_i (dpsm_dat_i),
        .dpsm_rd    (dpsm_rd),
        .dpsm_dat_o (dpsm_dat_o),
        .host_wr    (host_wr),
        .host_dat_i (host_dat_i),
        .host_rd    (host_rd),
        .host_dat_o (host_dat_o),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_half  (fifo_half),
        .fifocnt    (fifocnt),
        .overrun    (overrun),
        .underrun   (underrun)
    );

    always #5 sd_clk = ~sd_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: contents as a queue plus the last word delivered to each port
    logic [31:0] mq[$];
    logic [31:0] m_host, m_dpsm;
    bit          m_ovr, m_und;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_host = '0;
        m_dpsm = '0;
        m_ovr  = 0;
        m_und  = 0;
    endtask

    task automatic model_step();
        bit wsel, rtx, rsel, full, empty, new_ovr, new_und;
        logic [31:0] wd;
        wsel = en_rx ? dpsm_wr : host_wr;
        wd   = en_rx ? dpsm_dat_i : host_dat_i;
        rtx  = en_tx && !en_rx;
        rsel = rtx ? dpsm_rd : host_rd;
        if (flush) begin
            mq.delete();
            m_ovr = 0;
            m_und = 0;
        end else begin
            full    = (mq.size() == DEPTH);
            empty   = (mq.size() == 0);
            new_ovr = wsel && full && !rsel;
            new_und = rsel && empty;
            if (rsel && !empty) begin
                if (rtx) m_dpsm = mq.pop_front();
                else     m_host = mq.pop_front();
            end
            if (wsel && (!full || rsel)) mq.push_back(wd);
            m_ovr = new_ovr ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
            m_und = new_und ? 1'b1 : (clr_err ? 1'b0 : m_und);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ":host_dat"}, host_dat_o, m_host);
        check({ph, ":dpsm_dat"}, dpsm_dat_o, m_dpsm);
        check({ph, ":fifocnt"}, fifocnt, 32'(mq.size()));
        check({ph, ":full"}, 32'(fifo_full), 32'(mq.size() == DEPTH));
        check({ph, ":empty"}, 32'(fifo_empty), 32'(mq.size() == 0));
        check({ph, ":half"}, 32'(fifo_half), 32'(mq.size() >= DEPTH / 2));
        check({ph, ":overrun"}, 32'(overrun), 32'(m_ovr));
        check({ph, ":underrun"}, 32'(underrun), 32'(m_und));
    endtask

    task automatic tick(input string ph);
        @(posedge sd_clk);
        model_step();
        #1;
        check_all(ph);
    endtask

    task automatic idle();
        flush   = 0; clr_err = 0;
        dpsm_wr = 0; dpsm_rd = 0; host_wr = 0; host_rd = 0;
    endtask

    logic [31:0] rx_words [4];
    logic [31:0] held;

    initial begin
        rx_words[0] = 32'h03020100; rx_words[1] = 32'ha3a2a1a0;
        rx_words[2] = 32'hefbeadde; rx_words[3] = 32'had0dd0ba;
        rst = 1; en_rx = 0; en_tx = 0; dpsm_dat_i = '0; host_dat_i = '0;
        idle();
        model_reset();
        repeat (2) @(posedge sd_clk);
        #1;
        check_all("reset");
        check("reset_empty", 32'(fifo_empty), 32'd1);
        @(negedge sd_clk);
        rst = 0;

        // RX path: DPSM fills, host drains
        en_rx = 1;
        for (int i = 0; i < 4; i++) begin
            dpsm_wr = 1; dpsm_dat_i = rx_words[i];
            tick("rx_wr");
            check("rx_cnt_up", fifocnt, 32'(i + 1));
        end
        dpsm_wr = 0;
        for (int i = 0; i < 4; i++) begin
            host_rd = 1;
            tick("rx_rd");
            check("rx_data", host_dat_o, rx_words[i]);
            check("rx_cnt_dn", fifocnt, 32'(3 - i));
        end
        idle(); en_rx = 0;

        // TX path: idle host prefill, then DPSM reads
        host_wr = 1; host_dat_i = 32'h12345678; tick("tx_fill");
        host_dat_i = 32'haabbccdd; tick("tx_fill");
        host_wr = 0; en_tx = 1; dpsm_rd = 1;
        tick("tx_rd");
        check("tx_first", dpsm_dat_o, 32'h12345678);
        tick("tx_rd");
        check("tx_second", dpsm_dat_o, 32'haabbccdd);
        check("tx_empty", 32'(fifo_empty), 32'd1);
        idle(); en_tx = 0;

        // Full boundary
        flush = 1; tick("flush"); flush = 0;
        en_rx = 1;
        for (int i = 0; i < DEPTH; i++) begin
            dpsm_wr = 1; dpsm_dat_i = $urandom;
            tick("full_fill");
            if (i == 14) check("half_at_15", 32'(fifo_half), 32'd0);
            if (i == 15) check("half_at_16", 32'(fifo_half), 32'd1);
        end
        check("full_set", 32'(fifo_full), 32'd1);
        dpsm_dat_i = 32'hdeadbeef;
        tick("overrun");
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_cnt", fifocnt, 32'd32);
        dpsm_wr = 0; clr_err = 1; tick("clr"); clr_err = 0;
        dpsm_wr = 1; host_rd = 1; dpsm_dat_i = 32'h5a5a5a5a;
        tick("full_rdwr");
        check("full_rdwr_cnt", fifocnt, 32'd32);
        check("full_rdwr_ovr", 32'(overrun), 32'd0);
        idle(); en_rx = 0;

        // Empty boundary
        flush = 1; tick("flush"); flush = 0;
        held = m_host;
        host_rd = 1;
        tick("empty_rd");
        check("empty_rd_und", 32'(underrun), 32'd1);
        check("empty_rd_hold", host_dat_o, held);
        host_wr = 1; host_dat_i = 32'h0badf00d;
        tick("empty_rdwr");
        check("empty_rdwr_cnt", fifocnt, 32'd1);
        check("empty_rdwr_und", 32'(underrun), 32'd1);
        idle(); clr_err = 1; tick("clr_err"); clr_err = 0;
        check("clr_err_und", 32'(underrun), 32'd0);

        // Flush with a simultaneous write
        flush = 1; tick("flush"); flush = 0;
        for (int i = 0; i < 7; i++) begin
            host_wr = 1; host_dat_i = $urandom; tick("flush_fill");
        end
        host_rd = 0; host_wr = 0; tick("flush_pre");
        host_rd = 1; host_wr = 0; tick("flush_pre");
        host_rd = 0; host_wr = 1; host_dat_i = $urandom; tick("flush_pre");
        check("flush_pre_cnt", fifocnt, 32'd7);
        host_wr = 1; flush = 1; host_dat_i = 32'hcafef00d;
        tick("flush_wr");
        check("flush_cnt", fifocnt, 32'd0);
        check("flush_empty", 32'(fifo_empty), 32'd1);
        idle();
        tick("flush_after");
        check("flush_discard", fifocnt, 32'd0);

        // Randomized traffic across all direction modes
        for (int blk = 0; blk < 30; blk++) begin
            int unsigned mode, pw, pr;
            mode = $urandom_range(0, 3);
            en_rx = mode[0];
            en_tx = mode[1];
            pw = (blk % 3 == 0) ? 85 : ((blk % 3 == 1) ? 20 : 50);
            pr = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 85 : 50);
            for (int c = 0; c < 100; c++) begin
                dpsm_wr    = ($urandom_range(0, 99) < pw);
                host_wr    = ($urandom_range(0, 99) < pw);
                dpsm_rd    = ($urandom_range(0, 99) < pr);
                host_rd    = ($urandom_range(0, 99) < pr);
                dpsm_dat_i = $urandom;
                host_dat_i = $urandom;
                flush      = ($urandom_range(0, 199) == 0);
                clr_err    = ($urandom_range(0, 31) == 0);
                tick("rand");
            end
        end
        idle();

        // Asynchronous reset mid-transfer with five words held
        flush = 1; tick("flush"); flush = 0;
        en_rx = 1; en_tx = 0;
        for (int i = 0; i < 6; i++) begin
            dpsm_wr = 1; dpsm_dat_i = $urandom; tick("rst_fill");
        end
        dpsm_wr = 0; host_rd = 1; tick("rst_rd");
        host_rd = 0; dpsm_wr = 1; dpsm_dat_i = $urandom;
        check("rst_pre_cnt", fifocnt, 32'd5);
        @(posedge sd_clk);
        model_step();
        #3 rst = 1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst_cnt", fifocnt, 32'd0);
        check("async_rst_host", host_dat_o, 32'd0);
        idle(); en_rx = 0;
        @(negedge sd_clk);
        rst = 0;
        tick("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
